id_issue_stage: RTL

- Decode/issue pipeline stage that produces the operation interface consumed by the execute-stage ALU: one-hot 12-bit aluop, two 32-bit operands, and an overflow-trap enable.
- Accepts instruction words from fetch through a valid/ready handshake and reads the register file combinationally.
- Stalls on load-use hazards and presents a registered, flushable output to execute through a second valid/ready handshake.

---
 rtl/id_issue_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes one instruction per handshake into the
// execute-stage ALU bundle, with load-use stall and flush.
module id_issue_stage #(
  parameter int RF_ADDR_W = 5,
  parameter int DW        = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_inst,
  input  logic [DW-1:0]        if_pc,
  output logic [RF_ADDR_W-1:0] rf_raddr0,
  output logic [RF_ADDR_W-1:0] rf_raddr1,
  input  logic [DW-1:0]        rf_rdata0,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic                 ex_load_busy,
  input  logic [RF_ADDR_W-1:0] ex_load_dest,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [11:0]          ex_aluop,
  output logic [DW-1:0]        ex_src0,
  output logic [DW-1:0]        ex_src1,
  output logic                 ex_ov_en,
  output logic [RF_ADDR_W-1:0] ex_dest,
  output logic                 ex_wen,
  output logic [DW-1:0]        ex_pc,
  output logic                 ex_ri
);

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_AND  = 12'h200;
  localparam logic [11:0] OP_OR   = 12'h100;
  localparam logic [11:0] OP_NOR  = 12'h080;
  localparam logic [11:0] OP_XOR  = 12'h040;
  localparam logic [11:0] OP_SLT  = 12'h020;
  localparam logic [11:0] OP_SLTU = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  typedef struct packed {
    logic [11:0]          aluop;
    logic [DW-1:0]        src0;
    logic [DW-1:0]        src1;
    logic                 ov_en;
    logic [RF_ADDR_W-1:0] dest;
    logic                 wen;
    logic [DW-1:0]        pc;
    logic                 ri;
  } bundle_t;

  logic [5:0]           w_op;
  logic [5:0]           w_funct;
  logic [RF_ADDR_W-1:0] w_rs;
  logic [RF_ADDR_W-1:0] w_rt;
  logic [RF_ADDR_W-1:0] w_rd;
  logic [4:0]           w_sa;
  logic [15:0]          w_imm;
  logic [DW-1:0]        w_sext;
  logic [DW-1:0]        w_zext;
  logic [DW-1:0]        w_sa_ext;
  logic                 w_use_rs;
  logic                 w_use_rt;
  logic                 w_hazard;
  logic                 w_take;
  bundle_t              w_bun;

  logic                 r_valid;
  bundle_t              r_bun;

  assign w_op     = if_inst[31:26];
  assign w_rs     = if_inst[25:21];
  assign w_rt     = if_inst[20:16];
  assign w_rd     = if_inst[15:11];
  assign w_sa     = if_inst[10:6];
  assign w_funct  = if_inst[5:0];
  assign w_imm    = if_inst[15:0];
  assign w_sext   = {{(DW-16){w_imm[15]}}, w_imm};
  assign w_zext   = {{(DW-16){1'b0}}, w_imm};
  assign w_sa_ext = {{(DW-5){1'b0}}, w_sa};

  assign rf_raddr0 = w_rs;
  assign rf_raddr1 = w_rt;

  always_comb begin
    w_bun      = '0;
    w_bun.src0 = rf_rdata0;
    w_bun.src1 = rf_rdata1;
    w_bun.pc   = if_pc;
    w_bun.dest = w_rd;
    w_use_rs   = 1'b1;
    w_use_rt   = 1'b1;
    if (w_op == 6'h00) begin
      unique case (w_funct)
        6'h20: begin w_bun.aluop = OP_ADD; w_bun.ov_en = 1'b1; end
        6'h21: w_bun.aluop = OP_ADD;
        6'h22: begin w_bun.aluop = OP_SUB; w_bun.ov_en = 1'b1; end
        6'h23: w_bun.aluop = OP_SUB;
        6'h24: w_bun.aluop = OP_AND;
        6'h25: w_bun.aluop = OP_OR;
        6'h26: w_bun.aluop = OP_XOR;
        6'h27: w_bun.aluop = OP_NOR;
        6'h2a: w_bun.aluop = OP_SLT;
        6'h2b: w_bun.aluop = OP_SLTU;
        6'h00: begin
          w_bun.aluop = OP_SLL;
          w_bun.src0  = w_sa_ext;
          w_use_rs    = 1'b0;
        end
        6'h02: begin
          w_bun.aluop = OP_SRL;
          w_bun.src0  = w_sa_ext;
          w_use_rs    = 1'b0;
        end
        6'h03: begin
          w_bun.aluop = OP_SRA;
          w_bun.src0  = w_sa_ext;
          w_use_rs    = 1'b0;
        end
        6'h04: w_bun.aluop = OP_SLL;
        6'h06: w_bun.aluop = OP_SRL;
        6'h07: w_bun.aluop = OP_SRA;
        default: w_bun.ri = 1'b1;
      endcase
    end else begin
      w_bun.dest = w_rt;
      w_use_rt   = 1'b0;
      unique case (w_op)
        6'h08: begin
          w_bun.aluop = OP_ADD;
          w_bun.ov_en = 1'b1;
          w_bun.src1  = w_sext;
        end
        6'h09: begin w_bun.aluop = OP_ADD;  w_bun.src1 = w_sext; end
        6'h0a: begin w_bun.aluop = OP_SLT;  w_bun.src1 = w_sext; end
        6'h0b: begin w_bun.aluop = OP_SLTU; w_bun.src1 = w_sext; end
        6'h0c: begin w_bun.aluop = OP_AND;  w_bun.src1 = w_zext; end
        6'h0d: begin w_bun.aluop = OP_OR;   w_bun.src1 = w_zext; end
        6'h0e: begin w_bun.aluop = OP_XOR;  w_bun.src1 = w_zext; end
        6'h0f: begin
          w_bun.aluop = OP_LUI;
          w_bun.src1  = w_zext;
          w_use_rs    = 1'b0;
        end
        default: w_bun.ri = 1'b1;
      endcase
    end
    // a reserved instruction reads nothing, so it never stalls
    if (w_bun.ri) begin
      w_use_rs = 1'b0;
      w_use_rt = 1'b0;
    end
    w_bun.wen = !w_bun.ri && (w_bun.dest != '0);
  end

  assign w_hazard = ex_load_busy && (ex_load_dest != '0) &&
                    ((w_use_rs && (ex_load_dest == w_rs)) ||
                     (w_use_rt && (ex_load_dest == w_rt)));

  assign if_ready = (!r_valid || ex_ready) && !w_hazard && !flush;
  assign w_take   = if_valid && if_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_bun   <= '0;
    end else begin
      if (flush)         r_valid <= 1'b0;
      else if (w_take)   r_valid <= 1'b1;
      else if (ex_ready) r_valid <= 1'b0;
      if (w_take) r_bun <= w_bun;
    end
  end

  assign ex_valid = r_valid;
  assign ex_aluop = r_bun.aluop;
  assign ex_src0  = r_bun.src0;
  assign ex_src1  = r_bun.src1;
  assign ex_ov_en = r_bun.ov_en;
  assign ex_dest  = r_bun.dest;
  assign ex_wen   = r_bun.wen;
  assign ex_pc    = r_bun.pc;
  assign ex_ri    = r_bun.ri;

endmodule
